// File: rtl/odd_parity_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : odd_parity_pkg
// Purpose  : Shared types, constants and helpers for the odd-parity link
//            (receiver and transmitter).
// Revision : 1.0 - initial release
// ============================================================================
package odd_parity_pkg;

  // Receiver frame-walk states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 4;

  // start + data + parity + stop
  localparam int FRAME_BITS = DEF_DATA_W + 3;

  // Parity bit that gives data+parity an odd count of ones. Zero-extension
  // to 16 bits leaves the reduction unchanged, so any width up to 16 fits.
  function automatic logic odd_par(input logic [15:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/odd_parity_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : odd_parity_rx_if
// Purpose  : Serial input and valid/ready output bundle of the odd-parity
//            receiver. master = receiver side, slave = line/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface odd_parity_rx_if
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              bit_en;
  logic              rx_in;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    input  bit_en, rx_in, out_ready,
    output out_valid, out_data, parity_err, frame_err, overrun
  );

  modport slave (
    output bit_en, rx_in, out_ready,
    input  out_valid, out_data, parity_err, frame_err, overrun
  );

endinterface
`default_nettype wire

// File: rtl/odd_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : odd_parity_rx
// Purpose  : Odd-parity serial frame receiver. Deframes start/data/parity/
//            stop, checks parity and stop bit, and holds the word in a
//            one-entry valid/ready output register with overrun reporting.
// Revision : 1.0 - initial release
// ============================================================================
module odd_parity_rx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
)
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  odd_parity_rx_if.master bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;

  logic                w_start;
  logic                w_shift;
  logic                w_par_ld;
  logic                w_done;
  logic [DATA_W-1:0]   w_ins;
  logic                w_p_err;
  logic                w_f_err;

  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_perr;
  logic                r_ferr;
  logic                r_ovr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the frame only advances on bit strobes
  always_comb begin
    w_next = r_state;
    if (bus.bit_en) begin
      case (r_state)
        IDLE:    if (!bus.rx_in) w_next = DATA;
        DATA:    if (r_cnt == c_last_bit) w_next = PAR;
        PAR:     w_next = STOP;
        STOP:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // FSM-decoded strobes driving the datapath
  always_comb begin
    w_start  = bus.bit_en && (r_state == IDLE) && !bus.rx_in;
    w_shift  = bus.bit_en && (r_state == DATA);
    w_par_ld = bus.bit_en && (r_state == PAR);
    w_done   = bus.bit_en && (r_state == STOP);
    // New bit enters at the MSB; after DATA_W shifts the first bit sits at bit 0
    w_ins    = DATA_W'(bus.rx_in) << (DATA_W - 1);
    w_p_err  = (r_par != odd_par(16'(r_shift)));
    w_f_err  = ~bus.rx_in;
  end

  // Bit counter, shift register and latched parity bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_shift) begin
        r_cnt   <= r_cnt + 1'b1;
        r_shift <= (r_shift >> 1) | w_ins;
      end
      if (w_par_ld) begin
        r_par <= bus.rx_in;
      end
    end
  end

  // One-entry output register: a completed frame loads when the slot is
  // empty or being drained on the same edge; otherwise it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && (!r_valid || bus.out_ready)) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_perr  <= w_p_err;
        r_ferr  <= w_f_err;
      end else begin
        if (w_done) begin
          r_ovr <= 1'b1;
        end
        if (r_valid && bus.out_ready) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_data   = r_data;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_odd_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_odd_parity_rx
// Purpose  : Self-checking bench for odd_parity_rx: directed frames with
//            literal expectations plus randomized frames, all compared each
//            cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odd_parity_rx;

  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  odd_parity_rx_if #(.DATA_W(W)) bus ();

  odd_parity_rx #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Driver-announced frame contents for the edge that samples the stop bit
  logic         stop_edge  = 1'b0;
  logic [W-1:0] f_data     = '0;
  logic         f_perr     = 1'b0;
  logic         f_ferr     = 1'b0;
  bit           rand_ready = 1'b0;

  // Reference model of the output register
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic         m_perr  = 1'b0;
  logic         m_ferr  = 1'b0;
  logic         m_ovr   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a finished frame takes the slot if it is free or being drained,
  // otherwise it is lost and overrun flags for one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_perr  <= 1'b0;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      m_ovr <= 1'b0;
      if (stop_edge) begin
        if (!m_valid || bus.out_ready) begin
          m_valid <= 1'b1;
          m_data  <= f_data;
          m_perr  <= f_perr;
          m_ferr  <= f_ferr;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && bus.out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison, sampled well after the active edge
  always @(posedge clk) begin
    #2;
    check("out_valid", bus.out_valid, m_valid);
    check("overrun", bus.overrun, m_ovr);
    if (m_valid) begin
      check("out_data", bus.out_data, m_data);
      check("parity_err", bus.parity_err, m_perr);
      check("frame_err", bus.frame_err, m_ferr);
    end
  end

  task automatic step(input logic en, input logic b, input logic stp);
    @(negedge clk);
    bus.bit_en = en;
    bus.rx_in  = b;
    stop_edge  = stp;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) step(1'b0, b, 1'b0);
    step(1'b1, b, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stp,
                            input int gap, input bit ready_at_stop);
    send_bit(1'b0, gap);
    for (int i = 0; i < W; i++) send_bit(d[i], gap);
    send_bit(par, gap);
    f_data = d;
    f_perr = (($countones({d, par}) % 2) == 0);
    f_ferr = ~stp;
    repeat (gap) step(1'b0, stp, 1'b0);
    step(1'b1, stp, 1'b1);
    if (ready_at_stop) bus.out_ready = 1'b1;
  endtask

  function automatic logic good_par(input logic [W-1:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  initial begin
    bus.bit_en    = 1'b0;
    bus.rx_in     = 1'b1;
    bus.out_ready = 1'b1;

    // Reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Clean frame 4'hC
    send_frame(4'hC, 1'b1, 1'b1, 0, 0);
    idle(1);
    check("clean_valid", bus.out_valid, 1);
    check("clean_data", bus.out_data, 4'hC);
    check("clean_perr", bus.parity_err, 0);
    check("clean_ferr", bus.frame_err, 0);
    idle(1);
    check("clean_pulse", bus.out_valid, 0);

    // Parity: correct, then wrong
    send_frame(4'hB, 1'b0, 1'b1, 0, 0);
    idle(1);
    check("par_ok_perr", bus.parity_err, 0);
    idle(2);
    send_frame(4'hB, 1'b1, 1'b1, 0, 0);
    idle(1);
    check("par_bad_data", bus.out_data, 4'hB);
    check("par_bad_perr", bus.parity_err, 1);
    idle(2);

    // Stop bit 0
    send_frame(4'h1, 1'b0, 1'b0, 0, 0);
    idle(1);
    check("ferr_data", bus.out_data, 4'h1);
    check("ferr_ferr", bus.frame_err, 1);
    check("ferr_perr", bus.parity_err, 0);
    idle(2);

    // Backpressure and overrun
    bus.out_ready = 1'b0;
    send_frame(4'h3, 1'b1, 1'b1, 0, 0);
    idle(1);
    send_frame(4'h5, 1'b1, 1'b1, 0, 0);
    idle(1);
    check("ovr_pulse", bus.overrun, 1);
    check("ovr_hold", bus.out_data, 4'h3);
    idle(1);
    check("ovr_once", bus.overrun, 0);
    check("ovr_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    idle(1);
    check("ovr_drain", bus.out_valid, 0);
    idle(2);

    // Back-to-back, second completion coincides with consumption
    bus.out_ready = 1'b0;
    send_frame(4'h6, good_par(4'h6), 1'b1, 0, 0);
    send_frame(4'h9, good_par(4'h9), 1'b1, 0, 1);
    idle(1);
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_data", bus.out_data, 4'h9);
    check("b2b_ovr", bus.overrun, 0);
    idle(2);

    // Sparse strobes: bit_en every third clock
    send_frame(4'hC, 1'b1, 1'b1, 2, 0);
    idle(1);
    check("slow_data", bus.out_data, 4'hC);
    check("slow_perr", bus.parity_err, 0);
    check("slow_ferr", bus.frame_err, 0);
    idle(2);

    // Reset in the middle of a frame
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    @(negedge clk);
    bus.bit_en = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_ovr", bus.overrun, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(4'hA, 1'b1, 1'b1, 0, 0);
    idle(1);
    check("post_rst_data", bus.out_data, 4'hA);
    check("post_rst_perr", bus.parity_err, 0);
    check("post_rst_ferr", bus.frame_err, 0);
    idle(2);

    // Randomized frames with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] d;
      logic         p;
      logic         s;
      d = W'($urandom);
      p = ($urandom_range(0, 7) == 0) ? ~good_par(d) : good_par(d);
      s = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      send_frame(d, p, s, $urandom_range(0, 2), 0);
      idle($urandom_range(0, 2));
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/odd_parity_rx.md
Name: odd_parity_rx

Overview:
- Serial receiver and checker for odd-parity frames; the receive end of the team's odd-parity link.
- Frame on rx_in, LSB first, one bit per bit_en strobe: start(0), DATA_W data bits, parity bit, stop(1).
- Parity bit is the XNOR-reduction of the data bits, so data plus parity always holds an odd count of ones.
- Deframes, checks parity and stop bit, then presents the word through a one-entry valid/ready output register.

Parameters:
- DATA_W, 4, data bits per frame (legal range 1..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bit_en  input  1  bit strobe; rx_in is sampled only on clk edges where bit_en=1.
- rx_in  input  1  serial line; idles high.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
- out_valid  output  1  out_data and the error flags hold a completed frame.
- out_data  output  DATA_W  received word; bit 0 is the first data bit received.
- parity_err  output  1  qualified by out_valid; 1 when data plus parity holds an even count of ones.
- frame_err  output  1  qualified by out_valid; 1 when the stop bit sampled 0.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, bit counter=0, shift register=0.
  - out_valid=0, out_data=0, parity_err=0, frame_err=0, overrun=0.
  - Asserting reset mid-frame aborts the frame; no output results.
- Edges where bit_en=0: no state change; the output handshake still operates.
- FSM, evaluated only when bit_en=1:
  - IDLE: rx_in=0 -> DATA, counter=0. rx_in=1 -> stay.
  - DATA: shift rx_in into bit[counter] and increment the counter. After DATA_W bits -> PAR.
  - PAR: latch rx_in as the parity bit -> STOP.
  - STOP: sample rx_in, complete the frame -> IDLE.
- A new start bit is accepted on the first bit_en after STOP; no extra idle bit is required.
- Frame completion, on the STOP-sampling edge:
  - Computed values: p_err = ~(^{data, parity}), f_err = ~rx_in.
  - If out_valid=0, or out_valid=1 with out_ready=1 on the same edge:
    - load out_data, parity_err=p_err, frame_err=f_err; out_valid=1 next cycle.
    - In the simultaneous case the old word is consumed and out_valid stays 1 with the new contents.
  - If out_valid=1 and out_ready=0: drop the new frame, keep the held word, pulse overrun for exactly one cycle.
- Words with errors are still delivered; the error flags describe them.
- Handshake:
  - out_valid falls the cycle after out_valid and out_ready are both 1, unless a new frame loads on that same edge.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises one clk after the bit_en edge that samples the stop bit.
- A glitch start (rx_in low for one strobe) is not rejected; it is framed normally and a stop bit of 0 is reported via frame_err.

Decomposition:
- Shared package odd_parity_pkg:
  - state enum {IDLE, DATA, PAR, STOP};
  - FRAME_BITS = DATA_W + 3;
  - function odd_par(data) returning ~^data, for reuse by the transmitter.
- The counter width is $clog2(DATA_W+1).
- No sub-module; the FSM, shift register and output register are all in one file.

Test Plan:
- Clean frame: start, data 4'b1100 LSB first, parity 1, stop 1, out_ready=1 -> out_valid pulses one cycle with out_data=4'hC, parity_err=0, frame_err=0.
- Parity error: data 4'b1011, parity 0 -> parity_err=0. Repeat with parity 1 -> out_data=4'hB, parity_err=1.
- Frame error: data 4'b0001, parity 0, stop 0 -> out_data=4'h1, frame_err=1, parity_err=0.
- Backpressure and overrun:
  - out_ready=0; send 4'h3 then 4'h5 -> out_data stays 4'h3, overrun pulses exactly once.
  - Raise out_ready -> 4'h3 is consumed, then out_valid=0.
- Boundaries:
  - Back-to-back frames with out_ready=1 on the completion edge of the second frame -> both words delivered, out_valid continuous, no overrun.
  - bit_en asserted every third clk -> results identical to the clean-frame case.
- Reset mid-frame: assert rst_n=0 after 2 data bits -> all outputs 0 immediately. After release, a clean frame 4'hA (parity 1) -> out_data=4'hA, no error flags.
